// File: rtl/dm_arb_pkg.sv
// Shared constants for the data-memory port arbiter: operating modes and channel-id sizing.
package dm_arb_pkg;

    localparam logic [1:0] MODE_COM_ONLY  = 2'b00;
    localparam logic [1:0] MODE_PROC_ONLY = 2'b01;
    localparam logic [1:0] MODE_SHARED    = 2'b10;
    localparam logic [1:0] MODE_IDLE      = 2'b11;

    // Channel ids 0..num_proc-1 are processors; id num_proc is the COM channel.
    function automatic int chan_id_w(input int num_proc);
        return $clog2(num_proc + 1);
    endfunction

    function automatic int com_chan_id(input int num_proc);
        return num_proc;
    endfunction

endpackage

// File: rtl/dm_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from ptr+1 (mod NUM_PROC) for the first request.
module rr_arbiter #(
    parameter int NUM_PROC = 4,
    parameter int PTR_W    = 3
) (
    input  logic [NUM_PROC-1:0] req,
    input  logic [PTR_W-1:0]    ptr,
    output logic [NUM_PROC-1:0] gnt,
    output logic                any_grant
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_PROC; k++) begin
            for (int i = 0; i < NUM_PROC; i++) begin
                if (!found && req[i] && (i == (int'(ptr) + k) % NUM_PROC)) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

    assign any_grant = found;

endmodule

// File: rtl/dm_port_arbiter.sv
// Arbitrates COM and NUM_PROC processor channels onto one DM port with tagged read return.
// Optional contention counter enabled by defining DM_ARB_STATS_EN.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int NUM_PROC = 4,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int DM_LAT   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 mode,
    input  logic                       com_req,
    input  logic                       com_wr_en,
    input  logic [ADDR_W-1:0]          com_addr,
    input  logic [DATA_W-1:0]          com_data_in,
    output logic                       com_gnt,
    output logic [DATA_W-1:0]          com_data_out,
    output logic                       com_rvalid,
    input  logic [NUM_PROC-1:0]        proc_req,
    input  logic [NUM_PROC-1:0]        proc_wr_en,
    input  logic [NUM_PROC*ADDR_W-1:0] proc_addr,
    input  logic [NUM_PROC*DATA_W-1:0] proc_bus,
    output logic [NUM_PROC-1:0]        proc_gnt,
    output logic [DATA_W-1:0]          proc_data_out,
    output logic [NUM_PROC-1:0]        proc_rvalid,
    input  logic [DATA_W-1:0]          DM_out,
    output logic [DATA_W-1:0]          DM_data_in,
    output logic [ADDR_W-1:0]          DM_addr,
    output logic                       DM_write_en,
    output logic [15:0]                stall_cnt
);

    localparam int             CW     = chan_id_w(NUM_PROC);
    localparam logic [CW-1:0]  COM_ID = CW'(com_chan_id(NUM_PROC));

    logic                        com_mode_ok, proc_mode_ok;
    logic                        com_elig, com_win, rr_any;
    logic [NUM_PROC-1:0]         proc_elig, rr_gnt, proc_win;

    logic                        com_gnt_q, com_gnt_d;
    logic [NUM_PROC-1:0]         proc_gnt_q, proc_gnt_d;
    logic [CW-1:0]               rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]           dm_addr_q, dm_addr_d;
    logic [DATA_W-1:0]           dm_wdata_q, dm_wdata_d;
    logic                        dm_we_q, dm_we_d;
    logic                        rd_gnt_q, rd_gnt_d;
    logic [CW-1:0]               gnt_chan_q, gnt_chan_d;
    logic [DM_LAT-1:0]           tag_vld_q, tag_vld_d;
    logic [DM_LAT-1:0][CW-1:0]   tag_chan_q, tag_chan_d;
    logic [DATA_W-1:0]           com_rdata_q, com_rdata_d;
    logic [DATA_W-1:0]           proc_rdata_q, proc_rdata_d;
    logic                        com_rvalid_q, com_rvalid_d;
    logic [NUM_PROC-1:0]         proc_rvalid_q, proc_rvalid_d;

    // A channel granted last cycle is masked, so a held request cannot win twice in a row.
    assign com_mode_ok  = (mode == MODE_COM_ONLY) || (mode == MODE_SHARED);
    assign proc_mode_ok = (mode == MODE_PROC_ONLY) || (mode == MODE_SHARED);
    assign com_elig     = com_req & com_mode_ok & ~com_gnt_q;
    assign proc_elig    = proc_req & ~proc_gnt_q & {NUM_PROC{proc_mode_ok}};

    rr_arbiter #(
        .NUM_PROC (NUM_PROC),
        .PTR_W    (CW)
    ) u_rr (
        .req       (proc_elig),
        .ptr       (rr_ptr_q),
        .gnt       (rr_gnt),
        .any_grant (rr_any)
    );

    assign com_win  = com_elig;
    assign proc_win = com_win ? '0 : rr_gnt;

    always_comb begin
        com_gnt_d  = com_win;
        proc_gnt_d = proc_win;
        rr_ptr_d   = rr_ptr_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        dm_we_d    = 1'b0;
        rd_gnt_d   = 1'b0;
        gnt_chan_d = gnt_chan_q;
        if (com_win) begin
            dm_addr_d  = com_addr;
            dm_wdata_d = com_data_in;
            dm_we_d    = com_wr_en;
            rd_gnt_d   = ~com_wr_en;
            gnt_chan_d = COM_ID;
        end else if (rr_any) begin
            for (int i = 0; i < NUM_PROC; i++) begin
                if (proc_win[i]) begin
                    dm_addr_d  = proc_addr[i*ADDR_W +: ADDR_W];
                    dm_wdata_d = proc_bus[i*DATA_W +: DATA_W];
                    dm_we_d    = proc_wr_en[i];
                    rd_gnt_d   = ~proc_wr_en[i];
                    gnt_chan_d = CW'(i);
                    rr_ptr_d   = CW'(i);
                end
            end
        end
    end

    // Tag enters one cycle after the grant so its exit lines up with DM_out after DM_LAT.
    always_comb begin
        tag_vld_d     = '0;
        tag_chan_d    = '0;
        tag_vld_d[0]  = rd_gnt_q;
        tag_chan_d[0] = gnt_chan_q;
        for (int k = 1; k < DM_LAT; k++) begin
            tag_vld_d[k]  = tag_vld_q[k-1];
            tag_chan_d[k] = tag_chan_q[k-1];
        end
        com_rdata_d   = com_rdata_q;
        proc_rdata_d  = proc_rdata_q;
        com_rvalid_d  = 1'b0;
        proc_rvalid_d = '0;
        if (tag_vld_q[DM_LAT-1]) begin
            if (tag_chan_q[DM_LAT-1] == COM_ID) begin
                com_rdata_d  = DM_out;
                com_rvalid_d = 1'b1;
            end else begin
                proc_rdata_d = DM_out;
                for (int i = 0; i < NUM_PROC; i++) begin
                    if (tag_chan_q[DM_LAT-1] == CW'(i)) begin
                        proc_rvalid_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            com_gnt_q     <= 1'b0;
            proc_gnt_q    <= '0;
            rr_ptr_q      <= CW'(NUM_PROC - 1);
            dm_addr_q     <= '0;
            dm_wdata_q    <= '0;
            dm_we_q       <= 1'b0;
            rd_gnt_q      <= 1'b0;
            gnt_chan_q    <= '0;
            tag_vld_q     <= '0;
            tag_chan_q    <= '0;
            com_rdata_q   <= '0;
            proc_rdata_q  <= '0;
            com_rvalid_q  <= 1'b0;
            proc_rvalid_q <= '0;
        end else begin
            com_gnt_q     <= com_gnt_d;
            proc_gnt_q    <= proc_gnt_d;
            rr_ptr_q      <= rr_ptr_d;
            dm_addr_q     <= dm_addr_d;
            dm_wdata_q    <= dm_wdata_d;
            dm_we_q       <= dm_we_d;
            rd_gnt_q      <= rd_gnt_d;
            gnt_chan_q    <= gnt_chan_d;
            tag_vld_q     <= tag_vld_d;
            tag_chan_q    <= tag_chan_d;
            com_rdata_q   <= com_rdata_d;
            proc_rdata_q  <= proc_rdata_d;
            com_rvalid_q  <= com_rvalid_d;
            proc_rvalid_q <= proc_rvalid_d;
        end
    end

`ifdef DM_ARB_STATS_EN
    logic [15:0] stall_q, stall_d;
    logic        stall_pend;

    assign stall_pend = (com_elig & ~com_win) | (|(proc_elig & ~proc_win));

    always_comb begin
        stall_d = stall_q;
        if (stall_pend && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

    assign com_gnt       = com_gnt_q;
    assign proc_gnt      = proc_gnt_q;
    assign DM_addr       = dm_addr_q;
    assign DM_data_in    = dm_wdata_q;
    assign DM_write_en   = dm_we_q;
    assign com_data_out  = com_rdata_q;
    assign com_rvalid    = com_rvalid_q;
    assign proc_data_out = proc_rdata_q;
    assign proc_rvalid   = proc_rvalid_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench: two arbiters (DM_LAT=1 and DM_LAT=3) share stimulus, each with its own memory model.
module tb_dm_port_arbiter;

    localparam int NP = 4;
    localparam int DW = 16;
    localparam int AW = 16;
`ifdef DM_ARB_STATS_EN
    localparam int STALL_EXP = 10;
`else
    localparam int STALL_EXP = 0;
`endif

    logic            clk, rst;
    logic [1:0]      mode;
    logic            com_req, com_wr_en;
    logic [AW-1:0]   com_addr;
    logic [DW-1:0]   com_data_in;
    logic [NP-1:0]   proc_req, proc_wr_en;
    logic [NP*AW-1:0] proc_addr;
    logic [NP*DW-1:0] proc_bus;

    logic            com_gnt_1, com_rvalid_1, dm_we_1;
    logic [DW-1:0]   com_data_1, proc_data_1, dm_out_1, dm_din_1;
    logic [AW-1:0]   dm_addr_1;
    logic [NP-1:0]   proc_gnt_1, proc_rvalid_1;
    logic [15:0]     stall_1;

    logic            com_gnt_3, com_rvalid_3, dm_we_3;
    logic [DW-1:0]   com_data_3, proc_data_3, dm_out_3, dm_din_3;
    logic [AW-1:0]   dm_addr_3;
    logic [NP-1:0]   proc_gnt_3, proc_rvalid_3;
    logic [15:0]     stall_3;

    int n_vec = 0;
    int n_err = 0;

    dm_port_arbiter #(.NUM_PROC(NP), .DATA_W(DW), .ADDR_W(AW), .DM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .mode(mode),
        .com_req(com_req), .com_wr_en(com_wr_en), .com_addr(com_addr), .com_data_in(com_data_in),
        .com_gnt(com_gnt_1), .com_data_out(com_data_1), .com_rvalid(com_rvalid_1),
        .proc_req(proc_req), .proc_wr_en(proc_wr_en), .proc_addr(proc_addr), .proc_bus(proc_bus),
        .proc_gnt(proc_gnt_1), .proc_data_out(proc_data_1), .proc_rvalid(proc_rvalid_1),
        .DM_out(dm_out_1), .DM_data_in(dm_din_1), .DM_addr(dm_addr_1), .DM_write_en(dm_we_1),
        .stall_cnt(stall_1)
    );

    dm_port_arbiter #(.NUM_PROC(NP), .DATA_W(DW), .ADDR_W(AW), .DM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .mode(mode),
        .com_req(com_req), .com_wr_en(com_wr_en), .com_addr(com_addr), .com_data_in(com_data_in),
        .com_gnt(com_gnt_3), .com_data_out(com_data_3), .com_rvalid(com_rvalid_3),
        .proc_req(proc_req), .proc_wr_en(proc_wr_en), .proc_addr(proc_addr), .proc_bus(proc_bus),
        .proc_gnt(proc_gnt_3), .proc_data_out(proc_data_3), .proc_rvalid(proc_rvalid_3),
        .DM_out(dm_out_3), .DM_data_in(dm_din_3), .DM_addr(dm_addr_3), .DM_write_en(dm_we_3),
        .stall_cnt(stall_3)
    );

    // Memory models: synchronous read with DM_LAT register stages after the address register.
    logic [DW-1:0] mem1 [256];
    logic [DW-1:0] mem3 [256];
    logic [DW-1:0] rd1, rd3a, rd3b, rd3c;

    always @(posedge clk) begin
        if (dm_we_1) mem1[dm_addr_1[7:0]] <= dm_din_1;
        rd1 <= mem1[dm_addr_1[7:0]];
        if (dm_we_3) mem3[dm_addr_3[7:0]] <= dm_din_3;
        rd3a <= mem3[dm_addr_3[7:0]];
        rd3b <= rd3a;
        rd3c <= rd3b;
    end

    assign dm_out_1 = rd1;
    assign dm_out_3 = rd3c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic com_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        com_req     = 1'b1;
        com_wr_en   = 1'b1;
        com_addr    = a;
        com_data_in = d;
        tick();
        chk("com_wr_gnt", 32'(com_gnt_1), 32'h1);
        com_req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        mode = 2'b11;
        com_req = 1'b0; com_wr_en = 1'b0; com_addr = '0; com_data_in = '0;
        proc_req = '0; proc_wr_en = '0; proc_addr = '0; proc_bus = '0;
        tick();
        tick();
        chk("rst_com_gnt",  32'(com_gnt_1),  32'h0);
        chk("rst_proc_gnt", 32'(proc_gnt_1), 32'h0);
        chk("rst_dm_addr",  32'(dm_addr_1),  32'h0);
        chk("rst_dm_we",    32'(dm_we_1),    32'h0);
        chk("rst_stall",    32'(stall_1),    32'h0);
        rst = 1'b0;

        // Round robin with all four processors writing continuously.
        mode       = 2'b01;
        proc_req   = 4'hF;
        proc_wr_en = 4'hF;
        proc_addr  = {16'h0033, 16'h0032, 16'h0031, 16'h0030};
        proc_bus   = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("rr_gnt",  32'(proc_gnt_1), 32'(1 << (k % 4)));
            chk("rr_addr", 32'(dm_addr_1),  32'(16'h0030 + k % 4));
        end
        chk("stall_cnt",     32'(stall_1),       32'(STALL_EXP));
        chk("wr_no_rvalid",  32'(proc_rvalid_1), 32'h0);
        proc_req = '0;
        mode     = 2'b11;
        tick();
        chk("idle_gnt",     32'(proc_gnt_1), 32'h0);
        chk("idle_we",      32'(dm_we_1),    32'h0);
        chk("idle_addr_hold", 32'(dm_addr_1), 32'h0031);

        // COM write then read back through DM_LAT=1.
        mode        = 2'b00;
        com_req     = 1'b1;
        com_wr_en   = 1'b1;
        com_addr    = 16'h0010;
        com_data_in = 16'hBEEF;
        tick();
        chk("cw_gnt",  32'(com_gnt_1), 32'h1);
        chk("cw_we",   32'(dm_we_1),   32'h1);
        chk("cw_addr", 32'(dm_addr_1), 32'h0010);
        chk("cw_data", 32'(dm_din_1),  32'hBEEF);
        com_req = 1'b0;
        tick();
        chk("cw_gnt_pulse", 32'(com_gnt_1), 32'h0);
        chk("cw_we_pulse",  32'(dm_we_1),   32'h0);
        com_write(16'h0021, 16'h1234);
        com_write(16'h0023, 16'h5678);
        com_req   = 1'b1;
        com_wr_en = 1'b0;
        com_addr  = 16'h0010;
        tick();
        chk("cr_gnt", 32'(com_gnt_1), 32'h1);
        chk("cr_we",  32'(dm_we_1),   32'h0);
        com_req = 1'b0;
        tick();
        chk("cr_rv_early", 32'(com_rvalid_1), 32'h0);
        tick();
        chk("cr_rv",   32'(com_rvalid_1), 32'h1);
        chk("cr_data", 32'(com_data_1),   32'hBEEF);
        tick();
        chk("cr_rv_pulse", 32'(com_rvalid_1), 32'h0);
        chk("cr_data_hold", 32'(com_data_1),  32'hBEEF);
        tick();
        chk("cr3_rv",   32'(com_rvalid_3), 32'h1);
        chk("cr3_data", 32'(com_data_3),   32'hBEEF);

        // SHARED: COM and proc2 alternate.
        mode        = 2'b10;
        com_req     = 1'b1;
        com_wr_en   = 1'b1;
        com_addr    = 16'h0040;
        com_data_in = 16'h0000;
        proc_req    = 4'b0100;
        proc_wr_en  = 4'b0100;
        proc_addr   = {16'h0023, 16'h0042, 16'h0021, 16'h0030};
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("sh_com",  32'(com_gnt_1),  (k % 2 == 0) ? 32'h1 : 32'h0);
            chk("sh_proc", 32'(proc_gnt_1), (k % 2 == 0) ? 32'h0 : 32'h4);
        end
        com_req  = 1'b0;
        proc_req = '0;
        mode     = 2'b11;
        tick();

        // Back-to-back processor reads: proc1 then proc3.
        mode       = 2'b01;
        proc_wr_en = '0;
        proc_req   = 4'b0010;
        tick();
        chk("pr_gnt1", 32'(proc_gnt_3), 32'h2);
        proc_req = 4'b1000;
        tick();
        chk("pr_gnt3", 32'(proc_gnt_3), 32'h8);
        proc_req = '0;
        tick();
        chk("pr1_rv_l1",   32'(proc_rvalid_1), 32'h2);
        chk("pr1_data_l1", 32'(proc_data_1),   32'h1234);
        chk("pr_rv3_early", 32'(proc_rvalid_3), 32'h0);
        tick();
        chk("pr3_rv_l1",   32'(proc_rvalid_1), 32'h8);
        chk("pr3_data_l1", 32'(proc_data_1),   32'h5678);
        chk("pr_rv3_early2", 32'(proc_rvalid_3), 32'h0);
        tick();
        chk("pr1_rv_l3",   32'(proc_rvalid_3), 32'h2);
        chk("pr1_data_l3", 32'(proc_data_3),   32'h1234);
        tick();
        chk("pr3_rv_l3",   32'(proc_rvalid_3), 32'h8);
        chk("pr3_data_l3", 32'(proc_data_3),   32'h5678);
        tick();
        chk("pr_rv3_done",  32'(proc_rvalid_3), 32'h0);
        chk("pr_data3_hold", 32'(proc_data_3),  32'h5678);

        // Reset while a read is in flight.
        mode      = 2'b00;
        com_req   = 1'b1;
        com_wr_en = 1'b0;
        com_addr  = 16'h0010;
        tick();
        chk("mr_gnt", 32'(com_gnt_1), 32'h1);
        com_req = 1'b0;
        rst     = 1'b1;
        #1;
        chk("mr_com_gnt",   32'(com_gnt_1),   32'h0);
        chk("mr_dm_addr",   32'(dm_addr_1),   32'h0);
        chk("mr_dm_data",   32'(dm_din_1),    32'h0);
        chk("mr_com_data",  32'(com_data_1),  32'h0);
        chk("mr_proc_data", 32'(proc_data_3), 32'h0);
        chk("mr_stall",     32'(stall_1),     32'h0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("mr_no_rv1", 32'(com_rvalid_1), 32'h0);
            chk("mr_no_rv3", 32'(com_rvalid_3), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
